// File: rtl/frv_dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner ids and the select helper.
package frv_dmem_arbiter_pkg;

    // Owner ids recorded in the owner FIFO for each accepted request.
    localparam logic ARB_OWNER_M0 = 1'b0;
    localparam logic ARB_OWNER_M1 = 1'b1;

    // Picks the master to present when no handshake is in progress.
    // m1_first flips the default m0 priority (used when m1 has been starved).
    function automatic logic arb_pick(input logic m0_req,
                                      input logic m1_req,
                                      input logic m1_first);
        logic owner;
        owner = ARB_OWNER_M0;
        if (m1_first) begin
            owner = m1_req ? ARB_OWNER_M1 : ARB_OWNER_M0;
        end else begin
            owner = (!m0_req && m1_req) ? ARB_OWNER_M1 : ARB_OWNER_M0;
        end
        return owner;
    endfunction

endpackage

// File: rtl/frv_dmem_arb_owner_fifo.sv
// Owner FIFO: 1-bit entries recording which master issued each outstanding request.
// Pointers wrap naturally at DEPTH (power of 2); count is one bit wider than the pointers.
module frv_dmem_arb_owner_fifo
    import frv_dmem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage and write pointer: entry written at the tail on push.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_mem    <= {DEPTH{ARB_OWNER_M0}};
            r_wr_ptr <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= (DEPTH == 1) ? '0 : r_wr_ptr + 1'b1;
        end
    end

    // Read pointer advances past the head on pop.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_rd_ptr <= '0;
        end else if (w_do_pop) begin
            r_rd_ptr <= (DEPTH == 1) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/frv_dmem_arbiter.sv
// Data-memory port arbiter between the LSU (m0) and an auxiliary master (m1).
// Requests use req/gnt; responses return in order and are routed by the owner FIFO.
// Optional anti-starvation for m1 is enabled by defining FRV_DMEM_ARB_STARVE_EN.
module frv_dmem_arbiter
    import frv_dmem_arbiter_pkg::*;
#(
    parameter int XL           = 31,
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          g_clk,
    input  logic          g_reset,

    input  logic          m0_req,
    input  logic          m0_wen,
    input  logic [3:0]    m0_strb,
    input  logic [XL:0]   m0_wdata,
    input  logic [XL:0]   m0_addr,
    output logic          m0_gnt,
    output logic          m0_recv,
    output logic [XL:0]   m0_rdata,
    output logic          m0_error,

    input  logic          m1_req,
    input  logic          m1_wen,
    input  logic [3:0]    m1_strb,
    input  logic [XL:0]   m1_wdata,
    input  logic [XL:0]   m1_addr,
    output logic          m1_gnt,
    output logic          m1_recv,
    output logic [XL:0]   m1_rdata,
    output logic          m1_error,

    output logic          dmem_req,
    output logic          dmem_wen,
    output logic [3:0]    dmem_strb,
    output logic [XL:0]   dmem_wdata,
    output logic [XL:0]   dmem_addr,
    input  logic          dmem_gnt,
    input  logic          dmem_recv,
    input  logic [XL:0]   dmem_rdata,
    input  logic          dmem_error,

    output logic          arb_orphan
);

    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_head;
    logic w_issue;
    logic w_grant;
    logic w_pop;
    logic w_sel;
    logic w_m1_first;

    logic r_sel_lock;
    logic r_sel_prev;
    logic r_orphan;

    // No same-cycle bypass: a full FIFO blocks issue even if a response arrives.
    assign w_issue  = (m0_req || m1_req) && !w_fifo_full && !g_reset;
    assign w_grant  = w_issue && dmem_gnt;
    assign w_pop    = dmem_recv && !w_fifo_empty && !g_reset;
    assign dmem_req = w_issue;

`ifdef FRV_DMEM_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] r_starve_cnt;

    // Counts m0 grants taken while m1 waits; saturates so m1 keeps priority until served.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_starve_cnt <= '0;
        end else if (!m1_req || (w_grant && (w_sel == ARB_OWNER_M1))) begin
            r_starve_cnt <= '0;
        end else if (w_grant && (w_sel == ARB_OWNER_M0) &&
                     (r_starve_cnt != SW'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_m1_first = (r_starve_cnt == SW'(STARVE_LIMIT));
`else
    logic w_unused_starve_limit;

    assign w_m1_first            = 1'b0;
    assign w_unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    // Master selection: a stalled handshake keeps the master it started with.
    always_comb begin
        w_sel = ARB_OWNER_M0;
        if (r_sel_lock) begin
            w_sel = r_sel_prev;
        end else begin
            w_sel = arb_pick(m0_req, m1_req, w_m1_first);
        end
    end

    // Lock tracks a presented-but-not-accepted request so the mux cannot switch mid-handshake.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_sel_lock <= 1'b0;
            r_sel_prev <= ARB_OWNER_M0;
        end else if (w_issue) begin
            if (dmem_gnt) begin
                r_sel_lock <= 1'b0;
            end else begin
                r_sel_lock <= 1'b1;
                r_sel_prev <= w_sel;
            end
        end
    end

    // Response arriving with nothing outstanding is flagged one cycle later.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_orphan <= 1'b0;
        end else begin
            r_orphan <= dmem_recv && w_fifo_empty;
        end
    end

    frv_dmem_arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .push    (w_grant),
        .pop     (w_pop),
        .din     (w_sel),
        .head    (w_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign dmem_wen   = (w_sel == ARB_OWNER_M1) ? m1_wen   : m0_wen;
    assign dmem_strb  = (w_sel == ARB_OWNER_M1) ? m1_strb  : m0_strb;
    assign dmem_wdata = (w_sel == ARB_OWNER_M1) ? m1_wdata : m0_wdata;
    assign dmem_addr  = (w_sel == ARB_OWNER_M1) ? m1_addr  : m0_addr;

    assign m0_gnt   = w_grant && (w_sel == ARB_OWNER_M0);
    assign m1_gnt   = w_grant && (w_sel == ARB_OWNER_M1);
    assign m0_recv  = w_pop && (w_head == ARB_OWNER_M0);
    assign m1_recv  = w_pop && (w_head == ARB_OWNER_M1);
    assign m0_rdata = dmem_rdata;
    assign m1_rdata = dmem_rdata;
    assign m0_error = dmem_error && m0_recv;
    assign m1_error = dmem_error && m1_recv;

    assign arb_orphan = r_orphan;

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Self-checking bench for frv_dmem_arbiter (default OUTSTANDING=2, STARVE_LIMIT=4).
module tb_frv_dmem_arbiter;

    localparam int XL = 31;

    logic          g_clk;
    logic          g_reset;
    logic          m0_req, m0_wen, m0_gnt, m0_recv, m0_error;
    logic [3:0]    m0_strb;
    logic [XL:0]   m0_wdata, m0_addr, m0_rdata;
    logic          m1_req, m1_wen, m1_gnt, m1_recv, m1_error;
    logic [3:0]    m1_strb;
    logic [XL:0]   m1_wdata, m1_addr, m1_rdata;
    logic          dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_error;
    logic [3:0]    dmem_strb;
    logic [XL:0]   dmem_wdata, dmem_addr, dmem_rdata;
    logic          arb_orphan;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef FRV_DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    frv_dmem_arbiter dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .m0_req     (m0_req),
        .m0_wen     (m0_wen),
        .m0_strb    (m0_strb),
        .m0_wdata   (m0_wdata),
        .m0_addr    (m0_addr),
        .m0_gnt     (m0_gnt),
        .m0_recv    (m0_recv),
        .m0_rdata   (m0_rdata),
        .m0_error   (m0_error),
        .m1_req     (m1_req),
        .m1_wen     (m1_wen),
        .m1_strb    (m1_strb),
        .m1_wdata   (m1_wdata),
        .m1_addr    (m1_addr),
        .m1_gnt     (m1_gnt),
        .m1_recv    (m1_recv),
        .m1_rdata   (m1_rdata),
        .m1_error   (m1_error),
        .dmem_req   (dmem_req),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_wdata (dmem_wdata),
        .dmem_addr  (dmem_addr),
        .dmem_gnt   (dmem_gnt),
        .dmem_recv  (dmem_recv),
        .dmem_rdata (dmem_rdata),
        .dmem_error (dmem_error),
        .arb_orphan (arb_orphan)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every routed response is matched against the oldest expected entry.
    always @(negedge g_clk) begin
        exp_t e;
        if (m0_recv || m1_recv) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL recv_unexpected: m0_recv=%0b m1_recv=%0b, required no response",
                         m0_recv, m1_recv);
            end else begin
                e = exp_q.pop_front();
                if ({m1_recv, m0_recv} !== (e.id ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL recv_route: {m1,m0}_recv=%b, required %b",
                             {m1_recv, m0_recv}, (e.id ? 2'b10 : 2'b01));
                end
                n_checks++;
                if ((e.id ? m1_rdata : m0_rdata) !== e.data) begin
                    n_fail++;
                    $display("FAIL recv_rdata: got %h, required %h",
                             (e.id ? m1_rdata : m0_rdata), e.data);
                end
                n_checks++;
                if ({m1_error, m0_error} !== (e.err ? (e.id ? 2'b10 : 2'b01) : 2'b00)) begin
                    n_fail++;
                    $display("FAIL recv_error: {m1,m0}_error=%b, required %b", {m1_error, m0_error},
                             (e.err ? (e.id ? 2'b10 : 2'b01) : 2'b00));
                end
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Memory returns the data the scoreboard expects next (arbitrary when nothing is due).
    task automatic drive_recv();
        dmem_recv  = 1'b1;
        dmem_rdata = (exp_q.size() != 0) ? exp_q[0].data : 32'h0BAD_0BAD;
        dmem_error = (exp_q.size() != 0) ? exp_q[0].err : 1'b0;
    endtask

    task automatic test_reset();
        g_reset = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; dmem_gnt = 1'b1; dmem_recv = 1'b1;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_req: got %b, required 0", dmem_req); end
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b, required 00", {m0_gnt, m1_gnt}); end
        n_checks++;
        if ({m0_recv, m1_recv} !== 2'b00) begin n_fail++; $display("FAIL reset_recv: got %b, required 00", {m0_recv, m1_recv}); end
        n_checks++;
        if (arb_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_orphan: got %b, required 0", arb_orphan); end
        m0_req = 1'b0; m1_req = 1'b0; dmem_gnt = 1'b0; dmem_recv = 1'b0;
        tick();
        g_reset = 1'b0;
        tick();
        n_checks++;
        if ({dmem_req, arb_orphan} !== 2'b00) begin
            n_fail++; $display("FAIL post_reset_idle: {req,orphan}=%b, required 00", {dmem_req, arb_orphan});
        end
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_addr = 32'h100; m0_wen = 1'b0; dmem_gnt = 1'b1;
        #1;
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL single_gnt: {m0,m1}_gnt=%b, required 10", {m0_gnt, m1_gnt}); end
        n_checks++;
        if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL single_addr: got %h, required 00000100", dmem_addr); end
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
        tick();
        m0_req = 1'b0; dmem_gnt = 1'b0;
        tick();
        drive_recv();
        #1;
        n_checks++;
        if (m0_recv !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_recv: recv=%b rdata=%h, required 1 deadbeef", m0_recv, m0_rdata);
        end
        tick();
        dmem_recv = 1'b0;
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_two_masters();
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_addr = 32'h200; m1_wen = 1'b1; m1_strb = 4'hC; m1_wdata = 32'h1234_5678;
        dmem_gnt = 1'b1;
        #1;
        n_checks++;
        if ({m0_gnt, m1_gnt, dmem_addr} !== {2'b10, 32'h100}) begin
            n_fail++; $display("FAIL both_first: gnt=%b addr=%h, required 10 00000100", {m0_gnt, m1_gnt}, dmem_addr);
        end
        exp_q.push_back('{1'b0, 32'hA000_0000, 1'b0});
        tick();
        m0_req = 1'b0;
        #1;
        n_checks++;
        if ({m0_gnt, m1_gnt, dmem_addr} !== {2'b01, 32'h200}) begin
            n_fail++; $display("FAIL both_second: gnt=%b addr=%h, required 01 00000200", {m0_gnt, m1_gnt}, dmem_addr);
        end
        n_checks++;
        if ({dmem_wen, dmem_strb, dmem_wdata} !== {1'b1, 4'hC, 32'h1234_5678}) begin
            n_fail++; $display("FAIL both_wmux: wen=%b strb=%h wdata=%h, required 1 c 12345678", dmem_wen, dmem_strb, dmem_wdata);
        end
        exp_q.push_back('{1'b1, 32'hA000_0001, 1'b1});
        tick();
        m1_req = 1'b0; m1_wen = 1'b0; dmem_gnt = 1'b0;
        drive_recv();
        tick();
        drive_recv();
        tick();
        dmem_recv = 1'b0; dmem_error = 1'b0;
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL both_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_lock();
        m1_req = 1'b1; m1_addr = 32'h200; dmem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) m0_req = 1'b1;
            #1;
            n_checks++;
            if ({dmem_req, m0_gnt, m1_gnt, dmem_addr} !== {3'b100, 32'h200}) begin
                n_fail++; $display("FAIL lock_hold[%0d]: req/gnt=%b addr=%h, required 100 00000200",
                                   i, {dmem_req, m0_gnt, m1_gnt}, dmem_addr);
            end
            tick();
        end
        dmem_gnt = 1'b1;
        #1;
        n_checks++;
        if ({m0_gnt, m1_gnt, dmem_addr} !== {2'b01, 32'h200}) begin
            n_fail++; $display("FAIL lock_grant: gnt=%b addr=%h, required 01 00000200", {m0_gnt, m1_gnt}, dmem_addr);
        end
        exp_q.push_back('{1'b1, 32'hB000_0001, 1'b0});
        tick();
        m1_req = 1'b0;
        #1;
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL lock_next: gnt=%b, required 10", {m0_gnt, m1_gnt}); end
        exp_q.push_back('{1'b0, 32'hB000_0000, 1'b0});
        tick();
        m0_req = 1'b0; dmem_gnt = 1'b0;
        drive_recv();
        tick();
        drive_recv();
        tick();
        dmem_recv = 1'b0;
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL lock_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_full();
        m0_req = 1'b1; dmem_gnt = 1'b1;
        exp_q.push_back('{1'b0, 32'h4000_0001, 1'b0});
        tick();
        exp_q.push_back('{1'b0, 32'h4000_0002, 1'b0});
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({dmem_req, m0_gnt} !== 2'b00) begin
                n_fail++; $display("FAIL full_block[%0d]: {req,gnt}=%b, required 00", i, {dmem_req, m0_gnt});
            end
            tick();
        end
        drive_recv();
        #1;
        n_checks++;
        if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass: dmem_req=%b, required 0", dmem_req); end
        tick();
        dmem_recv = 1'b0;
        #1;
        n_checks++;
        if ({dmem_req, m0_gnt} !== 2'b11) begin
            n_fail++; $display("FAIL full_reopen: {req,gnt}=%b, required 11", {dmem_req, m0_gnt});
        end
        exp_q.push_back('{1'b0, 32'h4000_0003, 1'b0});
        tick();
        m0_req = 1'b0; dmem_gnt = 1'b0;
        drive_recv();
        tick();
        drive_recv();
        tick();
        dmem_recv = 1'b0;
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_orphan();
        drive_recv();
        #1;
        n_checks++;
        if ({m0_recv, m1_recv, arb_orphan} !== 3'b000) begin
            n_fail++; $display("FAIL orphan_same: recv/orphan=%b, required 000", {m0_recv, m1_recv, arb_orphan});
        end
        tick();
        dmem_recv = 1'b0;
        n_checks++;
        if (arb_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_pulse: got %b, required 1", arb_orphan); end
        tick();
        n_checks++;
        if (arb_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_clear: got %b, required 0", arb_orphan); end
    endtask

    task automatic test_starve();
        logic exp_m1;
        m0_req = 1'b1; m1_req = 1'b1; dmem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) drive_recv();
            #1;
            exp_m1 = STARVE && ((i % 5) == 4);
            n_checks++;
            if ({m0_gnt, m1_gnt} !== {!exp_m1, exp_m1}) begin
                n_fail++; $display("FAIL starve_order[%0d]: {m0,m1}_gnt=%b, required %b",
                                   i, {m0_gnt, m1_gnt}, {!exp_m1, exp_m1});
            end
            exp_q.push_back('{exp_m1, 32'h6000_0000 + 32'(i), 1'b0});
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0; dmem_gnt = 1'b0;
        drive_recv();
        tick();
        dmem_recv = 1'b0;
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL starve_drain: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        m0_req = 1'b1; dmem_gnt = 1'b1;
        exp_q.push_back('{1'b0, 32'h7000_0000, 1'b0});
        tick();
        exp_q.push_back('{1'b0, 32'h7000_0001, 1'b0});
        tick();
        g_reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if ({dmem_req, m0_gnt} !== 2'b00) begin
                n_fail++; $display("FAIL rst_mid_req[%0d]: {req,gnt}=%b, required 00", i, {dmem_req, m0_gnt});
            end
            tick();
        end
        g_reset = 1'b0; dmem_gnt = 1'b0;
        #1;
        n_checks++;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: dmem_req=%b, required 1", dmem_req); end
        tick();
        m0_req = 1'b0;
        drive_recv();
        #1;
        n_checks++;
        if ({m0_recv, m1_recv} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_recv: got %b, required 00", {m0_recv, m1_recv}); end
        tick();
        drive_recv();
        n_checks++;
        if (arb_orphan !== 1'b1) begin n_fail++; $display("FAIL rst_mid_orphan1: got %b, required 1", arb_orphan); end
        tick();
        dmem_recv = 1'b0;
        n_checks++;
        if (arb_orphan !== 1'b1) begin n_fail++; $display("FAIL rst_mid_orphan2: got %b, required 1", arb_orphan); end
        tick();
        n_checks++;
        if (arb_orphan !== 1'b0) begin n_fail++; $display("FAIL rst_mid_orphan_end: got %b, required 0", arb_orphan); end
    endtask

    initial begin
        g_reset = 1'b1;
        m0_req = 1'b0; m0_wen = 1'b0; m0_strb = 4'h0; m0_wdata = '0; m0_addr = '0;
        m1_req = 1'b0; m1_wen = 1'b0; m1_strb = 4'h0; m1_wdata = '0; m1_addr = '0;
        dmem_gnt = 1'b0; dmem_recv = 1'b0; dmem_rdata = '0; dmem_error = 1'b0;
        tick();
        test_reset();
        test_single_read();
        test_two_masters();
        test_lock();
        test_full();
        test_orphan();
        test_starve();
        test_reset_mid();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
